sdrc_app_arb: RTL and testbench
===============================

SDRC_APP_ARB -- requirements
Module: sdrc_app_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NCH, 4, number of application channels (2..8).
- APP_AW, 26, request address width.
- dw, 32, application data width.
- bl, 9, burst length width.
REQ-002 Clock and reset: one clock, sdram_clk; reset sdram_resetn is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning), one per line:
- sdram_clk  in  1  clock.
- sdram_resetn  in  1  async active-low reset.
- cfg_arb_mode  in  1  0 round-robin, 1 fixed priority (ch0 highest).
- ch_req  in  NCH  per-channel request.
- ch_req_addr  in  NCH*APP_AW  per-channel address, channel k at slice k.
- ch_req_len  in  NCH*bl  per-channel burst length.
- ch_req_wr_n  in  NCH  0 write, 1 read.
- ch_req_ack  out  NCH  request accepted.
- ch_wr_data  in  NCH*dw  per-channel write data.
- ch_wr_en_n  in  NCH*dw/8  per-channel byte enables, active low.
- ch_wr_next  out  NCH  write data consumed.
- ch_rd_valid  out  NCH  read data valid.
- ch_last_rd  out  NCH  last read beat.
- ch_rd_data  out  dw  read data, broadcast to all channels.
- app_req  out  1  request to the core.
- app_req_addr  out  APP_AW  request address to the core.
- app_req_len  out  bl  burst length to the core.
- app_req_wr_n  out  1  direction to the core.
- app_req_ack  in  1  core accepted the request.
- app_wr_data  out  dw  write data to the core.
- app_wr_en_n  out  dw/8  byte enables to the core.
- app_wr_next_req  in  1  core consumed a write beat.
- app_rd_data  in  dw  read data from the core.
- app_rd_valid  in  1  read data valid from the core.
- app_last_rd  in  1  last read beat from the core.
- app_last_wr  in  1  last write beat from the core.
- arb_gnt_id  out  clog2(NCH)  owning channel.
- arb_busy  out  1  state not IDLE.

Function
REQ-004 The FSM SHALL have three states, IDLE, REQ and XFR, and SHALL hold exactly one transfer in flight.
REQ-005 In IDLE, when any ch_req bit is set, the FSM SHALL register the winner into arb_gnt_id and enter REQ on the next edge.
REQ-006 Fixed-priority mode SHALL grant the lowest-index requester.
REQ-007 Round-robin mode SHALL search from rr_ptr upward, modulo NCH; rr_ptr resets to 0.
REQ-008 In REQ, app_req SHALL equal ch_req[g], and app_req_addr, app_req_len and app_req_wr_n SHALL be muxed from channel g.
REQ-009 Outside REQ, app_req SHALL be 0 and the address, length and direction outputs SHALL hold their last value.
REQ-010 ch_req_ack[g] SHALL equal app_req_ack while in REQ (combinational, same cycle); all other ack bits SHALL be 0.
REQ-011 On app_req_ack in REQ, the FSM SHALL enter XFR and latch the direction.
REQ-012 If ch_req[g] deasserts in REQ before ack, the FSM SHALL return to IDLE; rr_ptr SHALL be unchanged and no ack issued.
REQ-013 In XFR, app_wr_data and app_wr_en_n SHALL be muxed from channel g.
REQ-014 Outside XFR, app_wr_en_n SHALL be all 1s.
REQ-015 ch_wr_next[g] SHALL equal app_wr_next_req.
REQ-016 ch_rd_valid[g] SHALL equal app_rd_valid and ch_last_rd[g] SHALL equal app_last_rd.
REQ-017 Non-owning bits of ch_wr_next, ch_rd_valid and ch_last_rd SHALL be 0 at all times, including in IDLE and REQ.
REQ-018 ch_rd_data SHALL equal app_rd_data unconditionally.
REQ-019 XFR SHALL exit to IDLE on app_last_wr for a write, or on app_last_rd for a read, in the same cycle the last beat is routed.
REQ-020 The opposite-direction last signal SHALL be ignored in XFR.
REQ-021 On XFR exit, round-robin mode SHALL set rr_ptr to (g+1) mod NCH; fixed mode SHALL leave rr_ptr unchanged.
REQ-022 A new arbitration SHALL start in the IDLE cycle following XFR exit, giving a minimum of 1 idle cycle between grants.
REQ-023 A change of cfg_arb_mode SHALL take effect only at the next IDLE arbitration.
REQ-024 The FSM SHALL not grant a channel that is not requesting in the arbitration cycle.
REQ-025 Widths SHALL be fully parametric; clog2(NCH) SHALL be computed at elaboration, with a minimum width of 1.

Reset
REQ-026 sdram_resetn low SHALL asynchronously force IDLE, arb_gnt_id=0, rr_ptr=0, arb_busy=0, app_req=0, app_req_addr=0, app_req_len=0, app_req_wr_n=1 and app_wr_en_n all 1s.
REQ-027 Reset asserted mid-transfer SHALL abort without any further ch_* strobes; after release, the FSM SHALL restart arbitration from IDLE.

Verification
REQ-028 RR fairness: NCH=4, all ch_req held, 4-beat writes -> grants in order 0,1,2,3,0, each with exactly one ch_req_ack pulse.
REQ-029 Fixed priority: ch0 and ch2 requesting continuously, cfg_arb_mode=1 -> ch0 granted every time, ch2 never granted.
REQ-030 Read routing: ch1 reads len=8 -> 8 ch_rd_valid[1] pulses, ch_last_rd[1] on the 8th, ch_rd_valid[0,2,3]=0 throughout.
REQ-031 Withdraw: ch3 drops ch_req in REQ before ack -> back to IDLE, no ch_req_ack, next grant goes to the next requester.
REQ-032 Reset mid-XFR: sdram_resetn low during beat 2 of a write -> outputs at reset values immediately, arb_gnt_id=0, arb_busy=0.
REQ-033 Write mux: ch2 writes 0xA5A5_0000+i with byte enables 4'b0000 -> app_wr_data matches per beat; app_wr_en_n returns to 4'b1111 after app_last_wr.

Source files
------------

// File: rtl/sdrc_app_arb.sv
// Multi-channel front end for the SDRAM controller core: arbitrates NCH
// application channels onto one request/data port, one transfer at a time.
module sdrc_app_arb #(
  parameter int NCH    = 4,
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9,
  localparam int GW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_resetn,
  input  logic                    cfg_arb_mode,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH*APP_AW-1:0]   ch_req_addr,
  input  logic [NCH*bl-1:0]       ch_req_len,
  input  logic [NCH-1:0]          ch_req_wr_n,
  output logic [NCH-1:0]          ch_req_ack,
  input  logic [NCH*dw-1:0]       ch_wr_data,
  input  logic [NCH*dw/8-1:0]     ch_wr_en_n,
  output logic [NCH-1:0]          ch_wr_next,
  output logic [NCH-1:0]          ch_rd_valid,
  output logic [NCH-1:0]          ch_last_rd,
  output logic [dw-1:0]           ch_rd_data,
  output logic                    app_req,
  output logic [APP_AW-1:0]       app_req_addr,
  output logic [bl-1:0]           app_req_len,
  output logic                    app_req_wr_n,
  input  logic                    app_req_ack,
  output logic [dw-1:0]           app_wr_data,
  output logic [dw/8-1:0]         app_wr_en_n,
  input  logic                    app_wr_next_req,
  input  logic [dw-1:0]           app_rd_data,
  input  logic                    app_rd_valid,
  input  logic                    app_last_rd,
  input  logic                    app_last_wr,
  output logic [GW-1:0]           arb_gnt_id,
  output logic                    arb_busy
);

  localparam int BW = dw / 8;

  typedef enum logic [1:0] {IDLE, REQ, XFR} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              mode_q, mode_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [bl-1:0]     len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic [GW-1:0]     win;
  logic [GW-1:0]     idx;
  logic              in_req, in_xfr, last_beat;

  // Descending scan so the candidate closest to the search start wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (cfg_arb_mode) idx = GW'(i - 1);
      else              idx = GW'((32'(rr_ptr_q) + i - 1) % NCH);
      if (ch_req[idx]) win = idx;
    end
  end

  // wr_n_q doubles as the latched transfer direction: its last REQ-cycle
  // update is the ack cycle, so it holds the owner's direction through XFR.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_n_d    = wr_n_q;
    last_beat = wr_n_q ? app_last_rd : app_last_wr;
    unique case (state_q)
      IDLE: begin
        if (|ch_req) begin
          gnt_d   = win;
          mode_d  = cfg_arb_mode;
          state_d = REQ;
        end
      end
      REQ: begin
        addr_d = ch_req_addr[gnt_q*APP_AW +: APP_AW];
        len_d  = ch_req_len[gnt_q*bl +: bl];
        wr_n_d = ch_req_wr_n[gnt_q];
        if (app_req_ack)          state_d = XFR;
        else if (!ch_req[gnt_q])  state_d = IDLE;
      end
      XFR: begin
        if (last_beat) begin
          state_d = IDLE;
          if (!mode_q) rr_ptr_d = GW'((32'(gnt_q) + 1) % NCH);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wr_n_q   <= wr_n_d;
    end
  end

  // Owner strobes are gated to XFR so a reset or idle core never leaks a beat.
  always_comb begin
    in_req       = (state_q == REQ);
    in_xfr       = (state_q == XFR);
    app_req      = in_req & ch_req[gnt_q];
    app_req_addr = in_req ? ch_req_addr[gnt_q*APP_AW +: APP_AW] : addr_q;
    app_req_len  = in_req ? ch_req_len[gnt_q*bl +: bl] : len_q;
    app_req_wr_n = in_req ? ch_req_wr_n[gnt_q] : wr_n_q;
    app_wr_data  = in_xfr ? ch_wr_data[gnt_q*dw +: dw] : '0;
    app_wr_en_n  = in_xfr ? ch_wr_en_n[gnt_q*BW +: BW] : '1;
    ch_req_ack   = '0;
    ch_wr_next   = '0;
    ch_rd_valid  = '0;
    ch_last_rd   = '0;
    ch_req_ack[gnt_q]  = in_req & app_req_ack;
    ch_wr_next[gnt_q]  = in_xfr & app_wr_next_req;
    ch_rd_valid[gnt_q] = in_xfr & app_rd_valid;
    ch_last_rd[gnt_q]  = in_xfr & app_last_rd;
  end

  assign ch_rd_data = app_rd_data;
  assign arb_gnt_id = gnt_q;
  assign arb_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_sdrc_app_arb.sv
// Directed-sequence bench for sdrc_app_arb with a transaction-level
// arbitration model and a bench-side core that drives beats.
module tb_sdrc_app_arb;
  localparam int NCH = 4, AW = 26, DW = 32, BL = 9, BW = DW / 8;

  logic                 sdram_clk = 1'b0;
  logic                 sdram_resetn;
  logic                 cfg_arb_mode;
  logic [NCH-1:0]       ch_req, ch_req_wr_n, ch_req_ack;
  logic [NCH*AW-1:0]    ch_req_addr;
  logic [NCH*BL-1:0]    ch_req_len;
  logic [NCH*DW-1:0]    ch_wr_data;
  logic [NCH*BW-1:0]    ch_wr_en_n;
  logic [NCH-1:0]       ch_wr_next, ch_rd_valid, ch_last_rd;
  logic [DW-1:0]        ch_rd_data;
  logic                 app_req, app_req_wr_n, app_req_ack;
  logic [AW-1:0]        app_req_addr;
  logic [BL-1:0]        app_req_len;
  logic [DW-1:0]        app_wr_data, app_rd_data;
  logic [BW-1:0]        app_wr_en_n;
  logic                 app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr;
  logic [1:0]           arb_gnt_id;
  logic                 arb_busy;

  int total = 0;
  int bad   = 0;
  int m_rr  = 0;

  sdrc_app_arb #(.NCH(NCH), .APP_AW(AW), .dw(DW), .bl(BL)) dut (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .cfg_arb_mode(cfg_arb_mode),
    .ch_req(ch_req), .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
    .ch_req_wr_n(ch_req_wr_n), .ch_req_ack(ch_req_ack), .ch_wr_data(ch_wr_data),
    .ch_wr_en_n(ch_wr_en_n), .ch_wr_next(ch_wr_next), .ch_rd_valid(ch_rd_valid),
    .ch_last_rd(ch_last_rd), .ch_rd_data(ch_rd_data), .app_req(app_req),
    .app_req_addr(app_req_addr), .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n),
    .app_req_ack(app_req_ack), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_rd_data(app_rd_data),
    .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .app_last_wr(app_last_wr),
    .arb_gnt_id(arb_gnt_id), .arb_busy(arb_busy)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sdram_clk);
    #1;
  endtask

  // Candidate order is the fixed list 0..NCH-1 or that list rotated to rr.
  function automatic int exp_winner(input logic [NCH-1:0] req, input bit fixed, input int rr);
    int order[$];
    for (int k = 0; k < NCH; k++) order.push_back(fixed ? k : (rr + k) % NCH);
    foreach (order[k]) if (req[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic set_ch(input int c, input bit wr_n, input int len);
    ch_req_addr[c*AW +: AW] = AW'($urandom);
    ch_req_len[c*BL +: BL]  = BL'(len);
    ch_req_wr_n[c]          = wr_n;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge sdram_clk);
      if (app_req) ok = 1'b1;
      else cyc();
    end
    if (!ok) chk("req_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_strobes();
    app_req_ack = 0; app_wr_next_req = 0; app_rd_valid = 0;
    app_last_rd = 0; app_last_wr = 0;
  endtask

  // Full transaction for channel g as the core sees it; returns at the
  // negedge of the idle cycle after the last beat.
  task automatic run_txn(input int g, input bit pat);
    bit ok, rd, last;
    int len;
    logic [DW-1:0]  d;
    logic [BW-1:0]  e;
    logic [NCH-1:0] oh, el;
    rd  = ch_req_wr_n[g];
    len = int'(ch_req_len[g*BL +: BL]);
    oh  = NCH'(1) << g;
    wait_req(ok);
    if (!ok) return;
    chk("gnt", 64'(arb_gnt_id), 64'(g));
    chk("busy_req", 64'(arb_busy), 64'd1);
    chk("addr", 64'(app_req_addr), 64'(ch_req_addr[g*AW +: AW]));
    chk("len", 64'(app_req_len), 64'(len));
    chk("wr_n", 64'(app_req_wr_n), 64'(rd));
    chk("ack_early", 64'(ch_req_ack), 64'd0);
    cyc();
    app_req_ack = 1;
    @(negedge sdram_clk);
    chk("ack", 64'(ch_req_ack), 64'(oh));
    cyc();
    app_req_ack = 0;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      d = pat ? 32'hA5A5_0000 + DW'(i) : DW'($urandom);
      e = pat ? '0 : BW'($urandom);
      if (rd) begin
        app_rd_valid = 1; app_rd_data = d; app_last_rd = last;
        app_last_wr = (i == 0) && !last;
      end else begin
        ch_wr_data[g*DW +: DW] = d; ch_wr_en_n[g*BW +: BW] = e;
        app_wr_next_req = 1; app_last_wr = last;
        app_last_rd = (i == 0) && !last;
      end
      @(negedge sdram_clk);
      chk("busy_xfr", 64'(arb_busy), 64'd1);
      chk("ack_xfr", 64'(ch_req_ack), 64'd0);
      if (rd) begin
        el = last ? oh : '0;
        chk("rd_valid", 64'(ch_rd_valid), 64'(oh));
        chk("last_rd", 64'(ch_last_rd), 64'(el));
        chk("rd_data", 64'(ch_rd_data), 64'(d));
        chk("wr_next_rd", 64'(ch_wr_next), 64'd0);
      end else begin
        chk("wr_next", 64'(ch_wr_next), 64'(oh));
        chk("wr_data", 64'(app_wr_data), 64'(d));
        chk("wr_en_n", 64'(app_wr_en_n), 64'(e));
        chk("rd_valid_wr", 64'(ch_rd_valid), 64'd0);
      end
      cyc();
    end
    clear_strobes();
    @(negedge sdram_clk);
    chk("idle_after", 64'(arb_busy), 64'd0);
    chk("idle_gap_req", 64'(app_req), 64'd0);
    chk("en_n_idle", 64'(app_wr_en_n), 64'hF);
    chk("addr_hold", 64'(app_req_addr), 64'(ch_req_addr[g*AW +: AW]));
    if (!cfg_arb_mode) m_rr = (g + 1) % NCH;
  endtask

  initial begin
    bit ok;
    int g;
    sdram_resetn = 0; cfg_arb_mode = 0; ch_req = '0; ch_req_wr_n = '1;
    ch_req_addr = '0; ch_req_len = '0; ch_wr_data = '0; ch_wr_en_n = '1;
    app_rd_data = '0;
    clear_strobes();
    repeat (2) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("rst_app_req", 64'(app_req), 64'd0);
    chk("rst_addr", 64'(app_req_addr), 64'd0);
    chk("rst_len", 64'(app_req_len), 64'd0);
    chk("rst_wr_n", 64'(app_req_wr_n), 64'd1);
    chk("rst_en_n", 64'(app_wr_en_n), 64'hF);
    chk("rst_gnt", 64'(arb_gnt_id), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    sdram_resetn = 1;

    // Round-robin fairness, all channels writing 4 beats.
    for (int c = 0; c < NCH; c++) set_ch(c, 0, 4);
    ch_req = '1;
    repeat (5) begin
      g = exp_winner(ch_req, 0, m_rr);
      run_txn(g, 0);
      for (int c = 0; c < NCH; c++) set_ch(c, 0, 4);
    end

    // Fixed priority with ch0 and ch2 contending, random directions.
    cfg_arb_mode = 1;
    ch_req = 4'b0101;
    repeat (3) begin
      set_ch(0, 1'($urandom), 1 + int'($urandom_range(3)));
      set_ch(2, 1'($urandom), 1 + int'($urandom_range(3)));
      g = exp_winner(ch_req, 1, m_rr);
      run_txn(g, 0);
    end

    // Read routing, ch1 len 8.
    cfg_arb_mode = 0;
    set_ch(1, 1, 8);
    ch_req = 4'b0010;
    run_txn(exp_winner(ch_req, 0, m_rr), 0);

    // Withdraw in REQ before ack.
    for (int c = 0; c < NCH; c++) set_ch(c, 1'($urandom), 1 + int'($urandom_range(3)));
    ch_req = 4'b1001;
    wait_req(ok);
    chk("wd_gnt", 64'(arb_gnt_id), 64'(exp_winner(ch_req, 0, m_rr)));
    ch_req = 4'b0110;
    #1;
    chk("wd_app_req", 64'(app_req), 64'd0);
    chk("wd_ack", 64'(ch_req_ack), 64'd0);
    @(negedge sdram_clk);
    chk("wd_idle", 64'(arb_busy), 64'd0);
    chk("wd_ack2", 64'(ch_req_ack), 64'd0);
    run_txn(exp_winner(ch_req, 0, m_rr), 0);

    // Write data/byte-enable mux pattern on ch2.
    set_ch(2, 0, 4);
    ch_req = 4'b0100;
    run_txn(exp_winner(ch_req, 0, m_rr), 1);

    // Reset during the second beat of a write.
    set_ch(0, 0, 4);
    ch_req = 4'b0001;
    wait_req(ok);
    chk("rx_gnt", 64'(arb_gnt_id), 64'(exp_winner(ch_req, 0, m_rr)));
    cyc(); app_req_ack = 1;
    cyc(); app_req_ack = 0; app_wr_next_req = 1;
    cyc(); ch_wr_en_n[0 +: BW] = '0;
    #2 sdram_resetn = 0;
    #1;
    chk("rx_busy", 64'(arb_busy), 64'd0);
    chk("rx_gnt0", 64'(arb_gnt_id), 64'd0);
    chk("rx_app_req", 64'(app_req), 64'd0);
    chk("rx_addr", 64'(app_req_addr), 64'd0);
    chk("rx_len", 64'(app_req_len), 64'd0);
    chk("rx_wr_n", 64'(app_req_wr_n), 64'd1);
    chk("rx_en_n", 64'(app_wr_en_n), 64'hF);
    chk("rx_wr_next", 64'(ch_wr_next), 64'd0);
    clear_strobes();
    m_rr = 0;
    @(negedge sdram_clk);
    sdram_resetn = 1;
    set_ch(2, 1, 3);
    set_ch(3, 0, 2);
    ch_req = 4'b1100;
    run_txn(exp_winner(ch_req, 0, m_rr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
